// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data, occupancy count, almost flags
// and one-cycle overflow/underflow error pulses.
module sync_fifo #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    output logic [WIDTH-1:0]           data_out,
    output logic                       out_valid,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             pop_acc;

    // Handshake: a pop is accepted whenever the FIFO holds a word; a push is
    // accepted unless full, and a same-cycle accepted pop frees the slot for it.
    // Accepted pops present the word on data_out with out_valid one cycle later.
    assign pop_acc = pop & ~empty;
    assign wr_en   = push & (~full | pop_acc);

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Storage is never cleared; only the pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out_valid <= pop_acc;
            overflow  <= push & full & ~pop_acc;
            underflow <= pop & empty;
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: reset, ordering, error pulses, wrap,
// simultaneous push/pop and mid-operation reset.
module tb_sync_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CW    = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    int checks = 0;
    int errors = 0;
    logic [WIDTH-1:0] exp_q[$];

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out), .out_valid(out_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Apply inputs for one clock edge, then sample 1 time unit after it.
    task automatic cycle(input logic p, input logic po, input logic [WIDTH-1:0] d);
        push = p;
        pop = po;
        data_in = d;
        @(posedge clk);
        #1;
        push = 1'b0;
        pop = 1'b0;
        data_in = 'x;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cycle(1'b0, 1'b0, 'x);
        cycle(1'b0, 1'b0, 'x);
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", data_out); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if ({almost_empty, almost_full} !== 2'b10) begin errors++; $display("FAIL reset_almost got %b want 10", {almost_empty, almost_full}); end
        checks++; if ({overflow, underflow} !== 2'b00) begin errors++; $display("FAIL reset_err got %b want 00", {overflow, underflow}); end
        rst = 1'b0;
    endtask

    task automatic test_push_pop();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(32'hA000_0000 + i);
            cycle(1'b1, 1'b0, 32'hA000_0000 + i);
            checks++; if (count !== CW'(i + 1)) begin errors++; $display("FAIL pp_push_count got %0d want %0d", count, i + 1); end
            checks++; if (almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL pp_almost_empty got %b at count %0d", almost_empty, i + 1); end
        end
        for (int i = 0; i < 4; i++) begin
            exp = exp_q.pop_front();
            cycle(1'b0, 1'b1, 'x);
            checks++; if (data_out !== exp) begin errors++; $display("FAIL pp_data got %h want %h", data_out, exp); end
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pp_valid got %b want 1", out_valid); end
            checks++; if (count !== CW'(3 - i)) begin errors++; $display("FAIL pp_pop_count got %0d want %0d", count, 3 - i); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL pp_empty got %b want 1", empty); end
        cycle(1'b0, 1'b0, 'x);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pp_idle_valid got %b want 0", out_valid); end
        checks++; if (data_out !== 32'hA000_0003) begin errors++; $display("FAIL pp_hold got %h want a0000003", data_out); end
    endtask

    task automatic test_underflow();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 'x);
            checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_pulse got %b want 1", underflow); end
            checks++; if (data_out !== 32'hA000_0003) begin errors++; $display("FAIL uf_data got %h want a0000003", data_out); end
            checks++; if (count !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL uf_state count %0d valid %b want 0 0", count, out_valid); end
        end
        cycle(1'b0, 1'b0, 'x);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b want 0", underflow); end
    endtask

    task automatic test_fill(input logic [WIDTH-1:0] base);
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(base + i);
            cycle(1'b1, 1'b0, base + i);
            checks++; if (count !== CW'(i + 1)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 14)) begin errors++; $display("FAIL fill_almost_full got %b at count %0d", almost_full, i + 1); end
            checks++; if (full !== (i + 1 == 16)) begin errors++; $display("FAIL fill_full got %b at count %0d", full, i + 1); end
        end
        cycle(1'b1, 1'b0, base + 99);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fill_overflow got %b want 1", overflow); end
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL fill_ovf_count got %0d want 16", count); end
        cycle(1'b0, 1'b0, 'x);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fill_ovf_clear got %b want 0", overflow); end
        for (int i = 0; i < DEPTH; i++) begin
            exp = exp_q.pop_front();
            cycle(1'b0, 1'b1, 'x);
            checks++; if (data_out !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL fill_drain got %h/%b want %h/1", data_out, out_valid, exp); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %b want 1", empty); end
    endtask

    task automatic test_simultaneous();
        logic [WIDTH-1:0] exp;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(32'hB000_0000 + i);
            cycle(1'b1, 1'b0, 32'hB000_0000 + i);
        end
        for (int i = 0; i < 2; i++) begin
            exp = exp_q.pop_front();
            exp_q.push_back(32'hB100_0000 + i);
            cycle(1'b1, 1'b1, 32'hB100_0000 + i);
            checks++; if (count !== 5'd3) begin errors++; $display("FAIL sim_count got %0d want 3", count); end
            checks++; if (data_out !== exp) begin errors++; $display("FAIL sim_data got %h want %h", data_out, exp); end
        end
        for (int i = 0; i < 3; i++) begin
            exp = exp_q.pop_front();
            cycle(1'b0, 1'b1, 'x);
            checks++; if (data_out !== exp) begin errors++; $display("FAIL sim_drain got %h want %h", data_out, exp); end
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp_q.push_back(32'hC000_0000 + i);
            cycle(1'b1, 1'b0, 32'hC000_0000 + i);
        end
        exp = exp_q.pop_front();
        exp_q.push_back(32'hC0DE_0001);
        cycle(1'b1, 1'b1, 32'hC0DE_0001);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simfull_overflow got %b want 0", overflow); end
        checks++; if (count !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL simfull_count got %0d full %b want 16 1", count, full); end
        checks++; if (data_out !== exp) begin errors++; $display("FAIL simfull_data got %h want %h", data_out, exp); end
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            cycle(1'b0, 1'b1, 'x);
            checks++; if (data_out !== exp) begin errors++; $display("FAIL simfull_drain got %h want %h", data_out, exp); end
        end
    endtask

    task automatic test_empty_push_pop();
        cycle(1'b1, 1'b1, 32'hD00D_0001);
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL epp_underflow got %b want 1", underflow); end
        checks++; if (count !== 5'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL epp_state count %0d valid %b want 1 0", count, out_valid); end
        cycle(1'b0, 1'b1, 'x);
        checks++; if (data_out !== 32'hD00D_0001 || out_valid !== 1'b1) begin errors++; $display("FAIL epp_data got %h/%b want d00d0001/1", data_out, out_valid); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL epp_count got %0d want 0", count); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 32'hE000_0000 + i);
        checks++; if (count !== 5'd5) begin errors++; $display("FAIL rm_count got %0d want 5", count); end
        rst = 1'b1;
        cycle(1'b1, 1'b1, 32'hEEEE_EEEE);
        rst = 1'b0;
        checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL rm_cleared count %0d empty %b want 0 1", count, empty); end
        checks++; if (out_valid !== 1'b0 || data_out !== 32'h0) begin errors++; $display("FAIL rm_out got %h/%b want 0/0", data_out, out_valid); end
        cycle(1'b0, 1'b1, 'x);
        checks++; if (underflow !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL rm_underflow got %b valid %b want 1 0", underflow, out_valid); end
        exp_q.delete();
    endtask

    initial begin
        rst = 1'b1;
        push = 1'b0;
        pop = 1'b0;
        data_in = '0;
        test_reset();
        test_push_pop();
        test_underflow();
        test_fill(32'h1000_0000);
        test_fill(32'h2000_0000);
        test_simultaneous();
        test_empty_push_pop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
